// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
// The state enum and nibble-count helper are used by the controller.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int nib(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_add4.sv
// Combinational 4-bit ripple-carry adder slice.
// The serial controller reuses this slice once per nibble.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequences one 4-bit adder slice over WIDTH-bit operands, least significant nibble first.
// A valid/ready handshake is used on both the operand side and the result side.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBS  = nib(WIDTH);
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;

    logic [NIB_W-1:0]   slice_a;
    logic [NIB_W-1:0]   slice_b;
    logic [NIB_W-1:0]   slice_s;
    logic               slice_co;

    assign slice_a = a_reg[int'(idx)*NIB_W +: NIB_W];
    assign slice_b = b_reg[int'(idx)*NIB_W +: NIB_W];

    nibble_add4 u_add4 (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_reg),
        .s  (slice_s),
        .co (slice_co)
    );

    // Subtraction is folded into the accept: b is stored inverted with a forced carry-in of 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : ci;
                        idx       <= '0;
                        sum       <= '0;
                        cout      <= 1'b0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum[int'(idx)*NIB_W +: NIB_W] <= slice_s;
                    carry_reg <= slice_co;
                    if (idx == LAST_IDX) begin
                        cout      <= slice_co;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
